interleaver_pingpong_buffer: RTL and testbench

- Sits directly downstream of the block interleaver and upstream of the QPSK modulator.
- Captures each interleaved bit at its permuted index `data_out_index` into one bank of a two-bank (ping-pong) 192-bit store.
- Once a bank holds a full block, it streams that bank out in index order as 2-bit QPSK symbols with valid/ready handshake, while the other bank fills.
- Its `in_ready` drives the interleaver's `ready_buffer`.

---
 rtl/interleaver_pingpong_buffer.sv | 128 ++++++++++++
 tb/tb_interleaver_pingpong_buffer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/interleaver_pingpong_buffer.sv
// Two-bank ping-pong store between the block interleaver and the QPSK modulator.
// Bits are written at their permuted index; full banks stream out as NCPC-bit symbols.
module interleaver_pingpong_buffer #(
  parameter int NCBPS = 192,
  parameter int NCPC  = 2,
  parameter int IDXW  = $clog2(NCBPS)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  input  logic            in_data,
  input  logic [IDXW-1:0] in_index,
  output logic            in_ready,
  output logic            out_valid,
  output logic [NCPC-1:0] out_data,
  output logic            out_last,
  input  logic            out_ready,
  output logic            index_err
);

  localparam int              NSYM    = NCBPS / NCPC;
  localparam int              RDW     = (NSYM > 1) ? $clog2(NSYM) : 1;
  localparam logic [IDXW:0]   DEPTH   = (IDXW+1)'(NCBPS);
  localparam logic [IDXW-1:0] WR_LAST = IDXW'(NCBPS - 1);
  localparam logic [RDW-1:0]  RD_LAST = RDW'(NSYM - 1);

  logic [NCBPS-1:0] bank0_q;
  logic [NCBPS-1:0] bank1_q;
  logic [1:0]       full_q, full_d;
  logic             wr_bank_q, wr_bank_d;
  logic             rd_bank_q, rd_bank_d;
  logic [IDXW-1:0]  wr_cnt_q, wr_cnt_d;
  logic [RDW-1:0]   rd_cnt_q, rd_cnt_d;
  logic             index_err_q, index_err_d;
  logic             wr_hs_s;
  logic             rd_hs_s;
  logic             idx_ok_s;
  logic [NCBPS-1:0] rd_word_s;

  assign in_ready  = ~full_q[wr_bank_q];
  assign out_valid = full_q[rd_bank_q];
  assign out_last  = out_valid & (rd_cnt_q == RD_LAST);
  assign index_err = index_err_q;
  assign wr_hs_s   = in_valid & in_ready;
  assign rd_hs_s   = out_valid & out_ready;
  assign idx_ok_s  = ({1'b0, in_index} < DEPTH);
  assign rd_word_s = rd_bank_q ? bank1_q : bank0_q;

  // Lowest stored index of the pair lands in the symbol MSB.
  always_comb begin
    out_data = {NCPC{1'b0}};
    if (out_valid) begin
      for (int k = 0; k < NCPC; k++) begin
        out_data[NCPC-1-k] = rd_word_s[IDXW'(32'(rd_cnt_q) * NCPC + k)];
      end
    end else begin
      out_data = {NCPC{1'b0}};
    end
  end

  // Next-state: blocks complete by write count, not by which indices arrived.
  always_comb begin
    full_d      = full_q;
    wr_bank_d   = wr_bank_q;
    wr_cnt_d    = wr_cnt_q;
    rd_bank_d   = rd_bank_q;
    rd_cnt_d    = rd_cnt_q;
    index_err_d = index_err_q;
    if (wr_hs_s) begin
      if (!idx_ok_s) begin
        index_err_d = 1'b1;
      end else begin
        index_err_d = index_err_q;
      end
      if (wr_cnt_q == WR_LAST) begin
        full_d[wr_bank_q] = 1'b1;
        wr_bank_d         = ~wr_bank_q;
        wr_cnt_d          = {IDXW{1'b0}};
      end else begin
        wr_cnt_d = wr_cnt_q + IDXW'(1);
      end
    end else begin
      wr_cnt_d = wr_cnt_q;
    end
    if (rd_hs_s) begin
      if (rd_cnt_q == RD_LAST) begin
        full_d[rd_bank_q] = 1'b0;
        rd_bank_d         = ~rd_bank_q;
        rd_cnt_d          = {RDW{1'b0}};
      end else begin
        rd_cnt_d = rd_cnt_q + RDW'(1);
      end
    end else begin
      rd_cnt_d = rd_cnt_q;
    end
  end

  // Control state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      full_q      <= 2'b00;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_cnt_q    <= {IDXW{1'b0}};
      rd_cnt_q    <= {RDW{1'b0}};
      index_err_q <= 1'b0;
    end else begin
      full_q      <= full_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_cnt_q    <= wr_cnt_d;
      rd_cnt_q    <= rd_cnt_d;
      index_err_q <= index_err_d;
    end
  end

  // Bank storage has no reset; out-of-range indices are dropped here.
  always_ff @(posedge clk) begin
    if (wr_hs_s && idx_ok_s) begin
      if (wr_bank_q) begin
        bank1_q[in_index] <= in_data;
      end else begin
        bank0_q[in_index] <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_interleaver_pingpong_buffer.sv
// Randomized bench for interleaver_pingpong_buffer with a block/queue reference model.
module tb_interleaver_pingpong_buffer;

  localparam int NCBPS = 192;
  localparam int NSYM  = 96;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_data = 1'b0;
  logic [7:0] in_index = 8'd0;
  logic       out_ready = 1'b0;
  logic       in_ready;
  logic       out_valid;
  logic [1:0] out_data;
  logic       out_last;
  logic       index_err;

  interleaver_pingpong_buffer dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_index  (in_index),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_ready (out_ready),
    .index_err (index_err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: bank image per block parity plus a queue of pending symbols {last, data}.
  logic       mbank [2][NCBPS];
  logic [2:0] exp_q [$];
  int         m_wbank;
  int         m_wcnt;
  logic       m_err;
  bit         m_ir;
  bit         m_ov;
  int         sym_cnt = 0;
  int         last_pos [$];
  logic       stall_p = 1'b0;
  logic [1:0] stall_d = 2'b00;
  bit         chk_en = 1'b0;
  bit         ir_watch = 1'b0;
  bit         ir_low = 1'b0;
  int         or_mode = 0;
  logic       gd [NCBPS];

  function automatic int pending();
    return (exp_q.size() + NSYM - 1) / NSYM;
  endfunction

  initial begin
    for (int b = 0; b < 2; b++) begin
      for (int i = 0; i < NCBPS; i++) mbank[b][i] = 1'b0;
    end
    m_wbank = 0;
    m_wcnt  = 0;
    m_err   = 1'b0;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        exp_q.delete();
        m_wbank = 0;
        m_wcnt  = 0;
        m_err   = 1'b0;
        stall_p = 1'b0;
      end else begin
        m_ir = (pending() < 2);
        m_ov = (exp_q.size() != 0);
        if (out_valid && out_ready) begin
          if (out_last) last_pos.push_back(sym_cnt);
          sym_cnt++;
        end
        stall_p = out_valid && !out_ready;
        stall_d = out_data;
        if (m_ov && out_ready) void'(exp_q.pop_front());
        if (in_valid && m_ir) begin
          if (int'(in_index) < NCBPS) mbank[m_wbank][in_index] = in_data;
          else m_err = 1'b1;
          m_wcnt++;
          if (m_wcnt == NCBPS) begin
            for (int n = 0; n < NSYM; n++) begin
              exp_q.push_back({(n == NSYM - 1) ? 1'b1 : 1'b0,
                               mbank[m_wbank][2*n], mbank[m_wbank][2*n+1]});
            end
            m_wbank = 1 - m_wbank;
            m_wcnt  = 0;
          end
        end
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && chk_en) begin
        chk("in_ready", in_ready, 32'(pending() < 2));
        chk("out_valid", out_valid, 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) begin
          chk("out_data", out_data, exp_q[0][1:0]);
          chk("out_last", out_last, exp_q[0][2]);
        end else begin
          chk("idle_data", out_data, 2'b00);
          chk("idle_last", out_last, 1'b0);
        end
        chk("index_err", index_err, m_err);
        if (stall_p) begin
          chk("stall_valid", out_valid, 1'b1);
          chk("stall_data", out_data, stall_d);
        end
        if (ir_watch && !in_ready) ir_low = 1'b1;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      case (or_mode)
        0:       out_ready = 1'b0;
        1:       out_ready = 1'b1;
        2:       out_ready = 1'($urandom_range(0, 1));
        default: ;
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time %0t exceeded", $time);
    $fatal(1);
  end

  task automatic send_bit(input logic [7:0] idx, input logic d);
    int g = 0;
    in_valid = 1'b1;
    in_index = idx;
    in_data  = d;
    while (!in_ready && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 3000) begin
      total++;
      bad++;
      $display("FAIL send_timeout: waited %0d cycles for in_ready, want < 3000", g);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // kind 0: identity, data=index[0]; 1: interleaver j-sequence, random; 2: identity, random.
  task automatic send_block(input int kind, input int bad_k, input bit gaps);
    logic [7:0] idx;
    logic       d;
    for (int k = 0; k < NCBPS; k++) begin
      idx = (kind == 1) ? 8'(12 * (k % 16) + k / 16) : 8'(k);
      d   = (kind == 0) ? idx[0] : 1'($urandom_range(0, 1));
      if (k == bad_k) idx = 8'd200;
      gd[k] = d;
      if (gaps && $urandom_range(0, 7) == 0) @(negedge clk);
      send_bit(idx, d);
    end
  endtask

  task automatic drain();
    int g = 0;
    while ((out_valid || exp_q.size() != 0) && g < 3000) begin
      @(negedge clk);
      g++;
    end
    if (g >= 3000) begin
      total++;
      bad++;
      $display("FAIL drain_timeout: %0d symbols still pending", exp_q.size());
    end
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 2'b00);
    chk("rst_out_last", out_last, 1'b0);
    chk("rst_index_err", index_err, 1'b0);
    reset  = 1'b0;
    chk_en = 1'b1;

    // Identity fill
    or_mode = 1;
    sym_cnt = 0;
    last_pos.delete();
    send_block(0, -1, 1'b0);
    chk("t1_first_valid", out_valid, 1'b1);
    chk("t1_first_sym", out_data, 2'b01);
    drain();
    chk("t1_sym_cnt", sym_cnt, 96);
    chk("t1_last_cnt", last_pos.size(), 1);
    for (int i = 0; i < last_pos.size(); i++) chk("t1_last_pos", last_pos[i], 95);

    // Golden interleaver permutation with random bits and random backpressure
    or_mode = 2;
    send_block(1, -1, 1'b1);
    chk("t2_pin_sym0", exp_q[0][1:0], {gd[0], gd[16]});
    chk("t2_pin_sym1", exp_q[1][1:0], {gd[32], gd[48]});
    chk("t2_pin_sym95", exp_q[95][1:0], {gd[175], gd[191]});
    chk("t2_dut_sym0", out_data, {gd[0], gd[16]});
    drain();

    // Three back-to-back blocks
    or_mode = 1;
    sym_cnt = 0;
    last_pos.delete();
    ir_low   = 1'b0;
    ir_watch = 1'b1;
    repeat (3) send_block(2, -1, 1'b0);
    drain();
    ir_watch = 1'b0;
    chk("t3_in_ready_low", ir_low, 1'b0);
    chk("t3_sym_cnt", sym_cnt, 288);
    chk("t3_last_cnt", last_pos.size(), 3);
    for (int i = 0; i < last_pos.size(); i++) chk("t3_last_pos", last_pos[i], 95 + 96 * i);

    // Backpressure: both banks fill, then release
    or_mode   = 3;
    out_ready = 1'b0;
    for (int k = 0; k < 383; k++) send_bit(8'(k % NCBPS), 1'($urandom_range(0, 1)));
    chk("t4_ready_383", in_ready, 1'b1);
    send_bit(8'd191, 1'($urandom_range(0, 1)));
    chk("t4_ready_384", in_ready, 1'b0);
    in_valid = 1'b1;
    in_index = 8'd0;
    in_data  = 1'b1;
    repeat (5) @(negedge clk);
    chk("t4_stalled", in_ready, 1'b0);
    out_ready = 1'b1;
    repeat (95) @(negedge clk);
    chk("t4_ready_sym94", in_ready, 1'b0);
    @(negedge clk);
    chk("t4_ready_sym95", in_ready, 1'b1);
    send_bit(8'd0, 1'b1);
    or_mode = 2;
    for (int k = 1; k < NCBPS; k++) send_bit(8'(k), 1'($urandom_range(0, 1)));
    drain();

    // Out-of-range index
    send_block(2, 50, 1'b1);
    chk("t5_err_set", index_err, 1'b1);
    chk("t5_complete", out_valid, 1'b1);
    drain();
    send_block(2, -1, 1'b1);
    drain();
    chk("t5_err_sticky", index_err, 1'b1);

    // Reset mid-read and mid-write
    or_mode   = 3;
    out_ready = 1'b0;
    send_block(2, -1, 1'b0);
    out_ready = 1'b1;
    repeat (40) @(negedge clk);
    out_ready = 1'b0;
    for (int k = 0; k < 100; k++) send_bit(8'(k), 1'($urandom_range(0, 1)));
    chk("t6_pre_left", exp_q.size(), 56);
    chk("t6_pre_valid", out_valid, 1'b1);
    #2;
    reset = 1'b1;
    #1;
    chk("t6_rst_valid", out_valid, 1'b0);
    chk("t6_rst_ready", in_ready, 1'b1);
    chk("t6_rst_err", index_err, 1'b0);
    repeat (3) @(negedge clk);
    reset   = 1'b0;
    or_mode = 1;
    sym_cnt = 0;
    last_pos.delete();
    send_block(0, -1, 1'b0);
    chk("t6_first_sym", out_data, 2'b01);
    drain();
    chk("t6_sym_cnt", sym_cnt, 96);

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
